cs_micro_sequencer: RTL and testbench
=====================================

# cs_micro_sequencer

Microprogram sequencer for the control store. Holds the micro-program counter (uPC), produces the incremented next address and the 2-bit selection code for the control-store address multiplexer, and registers the address that multiplexer returns as the next uPC. It also provides a small micro-subroutine return stack (CALL/RET), which the multiplexer itself cannot supply. Sits in a loop with the address multiplexer: uPC drives the control-store ROM, and the ROM's condition/jump fields come back to this block in the same cycle.

## Interface

- DIRECTION_BUS_WIDTH, 11, control-store address width (W)
- RESET_ADDRESS, 0, uPC value after reset and after a stack underflow
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)

- CS_MicroSequencer_CLOCK_50  in  1  single clock, all state updates on rising edge
- CS_MicroSequencer_RESET_InLow  in  1  reset, synchronous, active-low
- CS_MicroSequencer_Stall_InLow  in  1  0 = hold all state this cycle
- CS_MicroSequencer_Cond_IN  in  3  branch-condition field of the current microinstruction
- CS_MicroSequencer_Flags_IN  in  4  {N,Z,C,V} from the datapath, valid in the same cycle
- CS_MicroSequencer_Address_IN  in  W  address selected by the address multiplexer
- CS_MicroSequencer_uPC_OUT  out  W  current uPC, drives control-store ROM address
- CS_MicroSequencer_Next_OUT  out  W  uPC+1, feeds the multiplexer's next input
- CS_MicroSequencer_Selection_OUT  out  2  multiplexer select: 00 next, 01 jump, 10 decode
- CS_MicroSequencer_Overflow_OUT  out  1  sticky: push attempted on full stack
- CS_MicroSequencer_Underflow_OUT  out  1  sticky: pop attempted on empty stack

## Operation

- Next_OUT = uPC + 1, truncated to W bits (all-ones wraps to 0).
- Selection_OUT is combinational from Cond_IN and Flags_IN:
  - 000 NEXT → 00; 001 JUMP → 01; 010 JZ → 01 if Z else 00; 011 JN → 01 if N else 00
  - 100 JC → 01 if C else 00; 101 DECODE → 10; 110 CALL → 01; 111 RET → 00 (multiplexer output ignored)
- uPC update (when not stalled): RET loads top-of-stack; all other codes load Address_IN.
- CALL: push Next_OUT (uPC+1) onto return stack in the same edge as the jump.
- RET: pop; uPC ← popped value.
- Stack pointer SP counts valid entries 0..STACK_DEPTH.
- CALL with SP = STACK_DEPTH: push dropped, stack unchanged, Overflow_OUT set to 1; jump still taken.
- RET with SP = 0: SP stays 0, uPC ← RESET_ADDRESS, Underflow_OUT set to 1.
- Error flags are sticky; only reset clears them.
- Stall_InLow = 0: uPC, SP, stack contents, error flags hold; Selection_OUT/Next_OUT remain combinational on held uPC.

## Timing

- Reset (RESET_InLow = 0 at a rising edge, takes priority over stall): uPC = RESET_ADDRESS, SP = 0, Overflow_OUT = 0, Underflow_OUT = 0; stack contents don't-care. Next_OUT = RESET_ADDRESS+1 after reset; Selection_OUT follows Cond_IN.
- Reset asserted mid-CALL/RET: the push/pop is discarded; reset state wins.
- One microinstruction per cycle: Cond_IN/Flags_IN/Address_IN sampled at edge k, new uPC visible after edge k (latency 1).
- CALL push and jump occur in the same edge; an immediately following RET (next cycle) returns the just-pushed address.
- No combinational path from Address_IN to any output (outputs depend only on registers, Cond_IN, Flags_IN).

## Test plan

- Reset then Cond=000 for 3 cycles → uPC 0x000, 0x001, 0x002, 0x003; Selection 00; flags 0.
- uPC = 0x7FF, Cond=000 → Next_OUT = 0x000, uPC wraps to 0x000.
- Cond=010 with Z=1, Address_IN=0x150 → Selection 01, uPC 0x150; repeat with Z=0 and Address_IN=Next → Selection 00, uPC+1.
- At uPC 0x010 Cond=110, Address_IN=0x200; then at 0x200 Cond=111 → uPC 0x200 then 0x011; SP back to 0.
- Five nested CALLs (depth 4) → Overflow_OUT = 1 after the fifth; four RETs return correct addresses; fifth RET → uPC = RESET_ADDRESS, Underflow_OUT = 1; both stay 1 until reset.
- Stall_InLow = 0 for 2 cycles during a CALL → uPC/SP unchanged; reset asserted while stalled → uPC = 0, SP = 0, flags 0.

Source files
------------

// File: rtl/cs_micro_sequencer.sv
// Control-store micro-sequencer: uPC register, next-address incrementer,
// address-mux select decode and a small CALL/RET return stack.
module cs_micro_sequencer #(
  parameter int          DIRECTION_BUS_WIDTH = 11,
  parameter int unsigned RESET_ADDRESS       = 0,
  parameter int          STACK_DEPTH         = 4
) (
  input  logic                           CS_MicroSequencer_CLOCK_50,
  input  logic                           CS_MicroSequencer_RESET_InLow,
  input  logic                           CS_MicroSequencer_Stall_InLow,
  input  logic [2:0]                     CS_MicroSequencer_Cond_IN,
  input  logic [3:0]                     CS_MicroSequencer_Flags_IN,
  input  logic [DIRECTION_BUS_WIDTH-1:0] CS_MicroSequencer_Address_IN,
  output logic [DIRECTION_BUS_WIDTH-1:0] CS_MicroSequencer_uPC_OUT,
  output logic [DIRECTION_BUS_WIDTH-1:0] CS_MicroSequencer_Next_OUT,
  output logic [1:0]                     CS_MicroSequencer_Selection_OUT,
  output logic                           CS_MicroSequencer_Overflow_OUT,
  output logic                           CS_MicroSequencer_Underflow_OUT
);

  localparam int W  = DIRECTION_BUS_WIDTH;
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int SW = AW + 1;

  localparam logic [W-1:0]  RST_A = W'(RESET_ADDRESS);
  localparam logic [SW-1:0] FULL  = SW'(STACK_DEPTH);

  localparam logic [2:0] C_NEXT = 3'b000;
  localparam logic [2:0] C_JUMP = 3'b001;
  localparam logic [2:0] C_JZ   = 3'b010;
  localparam logic [2:0] C_JN   = 3'b011;
  localparam logic [2:0] C_JC   = 3'b100;
  localparam logic [2:0] C_DEC  = 3'b101;
  localparam logic [2:0] C_CALL = 3'b110;
  localparam logic [2:0] C_RET  = 3'b111;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [2:0]    cond;
  logic          flag_n;
  logic          flag_z;
  logic          flag_c;
  logic          unused_flag_v;

  logic [W-1:0]  upc;
  logic [W-1:0]  upc_nx;
  logic [W-1:0]  nxt;
  logic [SW-1:0] sp;
  logic [SW-1:0] sp_dec;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  stack [STACK_DEPTH];
  logic          ovf;
  logic          unf;
  logic          is_call;
  logic          is_ret;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic [1:0]    sel;

  assign clk           = CS_MicroSequencer_CLOCK_50;
  assign rst_n         = CS_MicroSequencer_RESET_InLow;
  assign run           = CS_MicroSequencer_Stall_InLow;
  assign cond          = CS_MicroSequencer_Cond_IN;
  assign flag_n        = CS_MicroSequencer_Flags_IN[3];
  assign flag_z        = CS_MicroSequencer_Flags_IN[2];
  assign flag_c        = CS_MicroSequencer_Flags_IN[1];
  assign unused_flag_v = CS_MicroSequencer_Flags_IN[0];

  assign nxt     = upc + W'(1);
  assign is_call = (cond == C_CALL);
  assign is_ret  = (cond == C_RET);
  assign full    = (sp == FULL);
  assign empty   = (sp == '0);
  assign push_ok = run & is_call & ~full;
  assign pop_ok  = run & is_ret & ~empty;
  assign sp_dec  = sp - SW'(1);
  assign wr_idx  = sp[AW-1:0];
  assign rd_idx  = sp_dec[AW-1:0];

  always_comb begin
    sel = 2'b00;
    case (cond)
      C_NEXT:  sel = 2'b00;
      C_JUMP:  sel = 2'b01;
      C_JZ:    sel = flag_z ? 2'b01 : 2'b00;
      C_JN:    sel = flag_n ? 2'b01 : 2'b00;
      C_JC:    sel = flag_c ? 2'b01 : 2'b00;
      C_DEC:   sel = 2'b10;
      C_CALL:  sel = 2'b01;
      C_RET:   sel = 2'b00;
      default: sel = 2'b00;
    endcase
  end

  // RET bypasses the mux; an empty stack restarts the microprogram
  always_comb begin
    upc_nx = CS_MicroSequencer_Address_IN;
    if (is_ret)
      upc_nx = empty ? RST_A : stack[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc <= RST_A;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (run) begin
      upc <= upc_nx;
      if (push_ok)
        sp <= sp + SW'(1);
      else if (pop_ok)
        sp <= sp_dec;
      if (is_call && full)
        ovf <= 1'b1;
      if (is_ret && empty)
        unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok)
      stack[wr_idx] <= nxt;
  end

  assign CS_MicroSequencer_uPC_OUT       = upc;
  assign CS_MicroSequencer_Next_OUT      = nxt;
  assign CS_MicroSequencer_Selection_OUT = sel;
  assign CS_MicroSequencer_Overflow_OUT  = ovf;
  assign CS_MicroSequencer_Underflow_OUT = unf;

endmodule

// File: tb/tb_cs_micro_sequencer.sv
// Scoreboard bench for cs_micro_sequencer: directed micro-programs
// followed by random cycles against a queue-based return-stack model.
module tb_cs_micro_sequencer;

  localparam int W = 11;
  localparam int D = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] upc;
    logic         ovf;
    logic         unf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         stall_n;
  logic [2:0]   cond;
  logic [3:0]   flags;
  logic [W-1:0] addr;
  logic [W-1:0] upc;
  logic [W-1:0] nxt;
  logic [1:0]   sel;
  logic         ovf;
  logic         unf;

  exp_t         sb[$];
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_upc;
  logic         m_ovf;
  logic         m_unf;
  int           checks;
  int           failures;
  bit           done;

  cs_micro_sequencer #(
    .DIRECTION_BUS_WIDTH(W),
    .RESET_ADDRESS(0),
    .STACK_DEPTH(D)
  ) dut (
    .CS_MicroSequencer_CLOCK_50(clk),
    .CS_MicroSequencer_RESET_InLow(rst_n),
    .CS_MicroSequencer_Stall_InLow(stall_n),
    .CS_MicroSequencer_Cond_IN(cond),
    .CS_MicroSequencer_Flags_IN(flags),
    .CS_MicroSequencer_Address_IN(addr),
    .CS_MicroSequencer_uPC_OUT(upc),
    .CS_MicroSequencer_Next_OUT(nxt),
    .CS_MicroSequencer_Selection_OUT(sel),
    .CS_MicroSequencer_Overflow_OUT(ovf),
    .CS_MicroSequencer_Underflow_OUT(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_sel(logic [2:0] c, logic [3:0] f);
    logic taken;
    taken = (c == 3'd1) || (c == 3'd6) ||
            (c == 3'd2 && f[2]) ||
            (c == 3'd3 && f[3]) ||
            (c == 3'd4 && f[1]);
    if (c == 3'd5) return 2'b10;
    return taken ? 2'b01 : 2'b00;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit s, logic [2:0] c,
                      logic [3:0] f, logic [W-1:0] a);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    stall_n = s;
    cond    = c;
    flags   = f;
    addr    = a;
    if (!r) begin
      m_upc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (s) begin
      if (c == 3'd6) begin
        if (m_stk.size() < D) m_stk.push_back(m_upc + 1);
        else m_ovf = 1'b1;
        m_upc = a;
      end else if (c == 3'd7) begin
        if (m_stk.size() > 0) m_upc = m_stk.pop_back();
        else begin
          m_upc = '0;
          m_unf = 1'b1;
        end
      end else begin
        m_upc = a;
      end
    end
    e.sel = ref_sel(c, f);
    e.upc = m_upc;
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
  endtask

  task automatic seq_next();
    step(1, 1, 3'd0, 4'h0, m_upc + 1);
  endtask

  task automatic do_reset();
    step(0, 1, 3'd0, 4'h0, '0);
  endtask

  // monitor: DUT updates every cycle, compare one record per edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sel", int'(sel), int'(e.sel));
      chk("upc", int'(upc), int'(e.upc));
      chk("next", int'(nxt), int'(W'(e.upc + 1)));
      chk("ovf", int'(ovf), int'(e.ovf));
      chk("unf", int'(unf), int'(e.unf));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    done     = 0;
    rst_n    = 1'b0;
    stall_n  = 1'b1;
    cond     = 3'd0;
    flags    = 4'h0;
    addr     = '0;
    m_upc    = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;

    do_reset();
    do_reset();
    repeat (3) seq_next();

    step(1, 1, 3'd1, 4'h0, 11'h7FF);
    seq_next();
    seq_next();

    step(1, 1, 3'd2, 4'b0100, 11'h150);
    step(1, 1, 3'd2, 4'b1011, m_upc + 1);
    step(1, 1, 3'd3, 4'b1000, 11'h0A0);
    step(1, 1, 3'd4, 4'b0010, 11'h0B0);
    step(1, 1, 3'd5, 4'h0, 11'h333);

    step(1, 1, 3'd1, 4'h0, 11'h010);
    step(1, 1, 3'd6, 4'h0, 11'h200);
    step(1, 1, 3'd7, 4'h0, 11'h5A5);
    seq_next();

    do_reset();
    for (int i = 1; i <= 5; i++)
      step(1, 1, 3'd6, 4'h0, W'(i * 11'h100));
    for (int i = 0; i < 5; i++)
      step(1, 1, 3'd7, 4'h0, 11'h7AA);
    repeat (2) seq_next();

    do_reset();
    step(1, 1, 3'd1, 4'h0, 11'h040);
    step(1, 0, 3'd6, 4'h0, 11'h300);
    step(1, 0, 3'd6, 4'h0, 11'h300);
    step(1, 1, 3'd7, 4'h0, 11'h123);
    step(1, 1, 3'd6, 4'h0, 11'h300);
    step(0, 0, 3'd6, 4'h0, 11'h300);
    step(1, 1, 3'd7, 4'h0, 11'h111);

    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
           3'($urandom), 4'($urandom), W'($urandom));

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
